// File: rtl/tcs3200_pkg.sv
// Shared definitions for the TCS3200 colour capture block: filter codes,
// FSM state encoding and channel indices.
package tcs3200_pkg;

    localparam logic [1:0] FLT_RED   = 2'b00;
    localparam logic [1:0] FLT_GREEN = 2'b11;
    localparam logic [1:0] FLT_BLUE  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SETTLE,
        ST_GATE,
        ST_STORE,
        ST_PUBLISH
    } state_t;

    typedef enum logic [1:0] {
        CH_R,
        CH_G,
        CH_B
    } ch_t;

    function automatic logic [1:0] filter_code(input ch_t ch);
        case (ch)
            CH_R:    return FLT_RED;
            CH_G:    return FLT_GREEN;
            default: return FLT_BLUE;
        endcase
    endfunction

endpackage

// File: rtl/sensor_edge_sync.sv
// Brings the asynchronous sensor square wave into the clock domain and
// produces a one-cycle pulse per rising edge.
module sensor_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    // [0],[1] form the synchroniser; [2] holds the previous settled level
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tcs3200_rgb_capture.sv
// Sequences the TCS3200 through red, green and blue filters, counts sensor
// edges over a gate window per filter and publishes a 24-bit RGB frame.
module tcs3200_rgb_capture
    import tcs3200_pkg::*;
#(
    parameter int SETTLE_CYCLES = 10000,
    parameter int GATE_CYCLES   = 1000000,
    parameter int CNT_W         = 20,
    parameter int SHIFT         = 2
) (
    input  logic        clk_100MHz,
    input  logic        Rst,
    input  logic        enable,
    input  logic        sensor_out,
    output logic        S0,
    output logic        S1,
    output logic        S2,
    output logic        S3,
    output logic [23:0] RGB_Data,
    output logic        data_valid,
    output logic        busy
);

    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_BYTE    = CNT_W'(255);

    state_t             state_q;
    ch_t                ch_q;
    logic [1:0]         flt_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         shr_q, shg_q, shb_q;
    logic [23:0]        rgb_q;
    logic               data_valid_q;
    logic               busy_q;
    logic               rise;
    logic [7:0]         byte_d;

    function automatic logic [7:0] sat_byte(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] s;
        s = c >> SHIFT;
        return (s > CNT_BYTE) ? 8'hFF : s[7:0];
    endfunction

    sensor_edge_sync u_sync (
        .clk_i   (clk_100MHz),
        .rst_ni  (Rst),
        .async_i (sensor_out),
        .rise_o  (rise)
    );

    assign byte_d = sat_byte(cnt_q);

    always_ff @(posedge clk_100MHz or negedge Rst) begin
        if (!Rst) begin
            state_q      <= ST_IDLE;
            ch_q         <= CH_R;
            flt_q        <= FLT_RED;
            tmr_q        <= '0;
            cnt_q        <= '0;
            shr_q        <= 8'h00;
            shg_q        <= 8'h00;
            shb_q        <= 8'h00;
            rgb_q        <= 24'h000000;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_SEL;
                        ch_q    <= CH_R;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SEL: begin
                    flt_q   <= filter_code(ch_q);
                    cnt_q   <= '0;
                    tmr_q   <= '0;
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (tmr_q == SETTLE_LAST) begin
                        tmr_q   <= '0;
                        state_q <= ST_GATE;
                    end else begin
                        tmr_q <= tmr_q + TMR_ONE;
                    end
                end
                ST_GATE: begin
                    // Saturate instead of wrapping so a fast sensor reads as bright
                    if (rise && (cnt_q != '1)) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                    if (tmr_q == GATE_LAST) begin
                        state_q <= ST_STORE;
                    end else begin
                        tmr_q <= tmr_q + TMR_ONE;
                    end
                end
                ST_STORE: begin
                    case (ch_q)
                        CH_R: begin
                            shr_q   <= byte_d;
                            ch_q    <= CH_G;
                            state_q <= ST_SEL;
                        end
                        CH_G: begin
                            shg_q   <= byte_d;
                            ch_q    <= CH_B;
                            state_q <= ST_SEL;
                        end
                        default: begin
                            shb_q        <= byte_d;
                            data_valid_q <= 1'b1;
                            state_q      <= ST_PUBLISH;
                        end
                    endcase
                end
                ST_PUBLISH: begin
                    rgb_q <= {shr_q, shg_q, shb_q};
                    if (enable) begin
                        state_q <= ST_SEL;
                        ch_q    <= CH_R;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign S0         = 1'b1;
    assign S1         = 1'b0;
    assign S2         = flt_q[1];
    assign S3         = flt_q[0];
    assign RGB_Data   = rgb_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tcs3200_rgb_capture.sv
// Bench for tcs3200_rgb_capture: a filter-dependent square-wave sensor model
// drives two instances (short and long gate) and frames are checked against
// counts derived from period arithmetic.
module tb_tcs3200_rgb_capture;

    localparam int SET       = 10;
    localparam int GATE      = 100;
    localparam int GATE_SAT  = 1000;
    localparam int SHIFT     = 0;
    localparam int FRAME     = 3 * (SET + GATE + 2) + 1;
    localparam int FRAME_SAT = 3 * (SET + GATE_SAT + 2) + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, en_sat;
    logic        sens_a, sens_b;
    logic        s0, s1, s2, s3, dv, busy;
    logic        s0b, s1b, s2b, s3b, dvb, busyb;
    logic [23:0] rgb, rgbb;

    int n_checks = 0;
    int n_fail   = 0;
    int dv_cnt   = 0;
    int per[4];

    always #5 clk = ~clk;

    tcs3200_rgb_capture #(
        .SETTLE_CYCLES(SET), .GATE_CYCLES(GATE), .CNT_W(20), .SHIFT(SHIFT)
    ) dut (
        .clk_100MHz(clk), .Rst(rst_n), .enable(en), .sensor_out(sens_a),
        .S0(s0), .S1(s1), .S2(s2), .S3(s3),
        .RGB_Data(rgb), .data_valid(dv), .busy(busy)
    );

    tcs3200_rgb_capture #(
        .SETTLE_CYCLES(SET), .GATE_CYCLES(GATE_SAT), .CNT_W(20), .SHIFT(SHIFT)
    ) dut_sat (
        .clk_100MHz(clk), .Rst(rst_n), .enable(en_sat), .sensor_out(sens_b),
        .S0(s0b), .S1(s1b), .S2(s2b), .S3(s3b),
        .RGB_Data(rgbb), .data_valid(dvb), .busy(busyb)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: edges in a gate window = gate/period, then shift and clamp
    function automatic int exp_byte(input int p, input int gate);
        int v;
        v = (gate / p) >> SHIFT;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [23:0] exp_rgb(input int gate);
        return {8'(exp_byte(per[0], gate)), 8'(exp_byte(per[3], gate)), 8'(exp_byte(per[1], gate))};
    endfunction

    // Sensor model: square wave whose period follows the selected filter,
    // phase restarting whenever the filter code changes
    initial begin
        int ph[2];
        logic [1:0] last[2];
        logic [1:0] code;
        ph = '{0, 0};
        last = '{2'b00, 2'b00};
        sens_a = 1'b0;
        sens_b = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                code = (k == 0) ? {s2, s3} : {s2b, s3b};
                if (code != last[k]) begin
                    ph[k] = 0;
                    last[k] = code;
                end else begin
                    ph[k] = (ph[k] + 1) % per[code];
                end
            end
            sens_a = (ph[0] < per[{s2, s3}] / 2);
            sens_b = (ph[1] < per[{s2b, s3b}] / 2);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (dv) dv_cnt++;
        end
    end

    task automatic run_frame(input logic [23:0] exp, input logic [23:0] prev,
                             input int drop_lat, input logic exp_busy);
        int n;
        int lat;
        logic [1:0] seq[$];
        @(negedge clk);
        en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 5);
        check_eq("start_busy", busy, 1);
        lat = 1;
        if (drop_lat == 1) en = 1'b0;
        while (!dv && lat < FRAME + 50) begin
            @(negedge clk);
            lat++;
            if (lat == drop_lat) en = 1'b0;
            if (busy && (seq.size() == 0 || seq[$] != {s2, s3})) seq.push_back({s2, s3});
        end
        check_eq("frame_len", lat, FRAME);
        check_eq("rgb_hold_at_dv", rgb, prev);
        check_eq("filter_seq_len", seq.size(), 3);
        if (seq.size() == 3) begin
            check_eq("filter_red", seq[0], 2'b00);
            check_eq("filter_green", seq[1], 2'b11);
            check_eq("filter_blue", seq[2], 2'b01);
        end
        @(negedge clk);
        check_eq("rgb_frame", rgb, exp);
        check_eq("dv_one_cycle", dv, 0);
        check_eq("busy_after", busy, exp_busy);
    endtask

    initial begin
        logic [23:0] e;
        int n;
        int lat;
        int dv_base;
        per = '{10, 10, 10, 10};
        rst_n = 1'b0;
        en = 1'b0;
        en_sat = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_rgb", rgb, 24'h0);
        check_eq("rst_dv", dv, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_flt", {s2, s3}, 2'b00);
        check_eq("rst_s0", s0, 1);
        check_eq("rst_s1", s1, 0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_dv_cnt", dv_cnt, 0);
        check_eq("idle_rgb", rgb, 24'h0);

        // Equal periods on all filters
        e = exp_rgb(GATE);
        run_frame(e, 24'h0, 1, 1'b0);

        // Distinct periods per filter
        per[0] = 4; per[3] = 10; per[1] = 20;
        run_frame(exp_rgb(GATE), e, 1, 1'b0);
        e = exp_rgb(GATE);

        // Long gate, fast sensor: raw count exceeds a byte
        per = '{2, 2, 2, 2};
        @(negedge clk);
        en_sat = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busyb && n < 5);
        en_sat = 1'b0;
        lat = 1;
        while (!dvb && lat < FRAME_SAT + 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq("sat_frame_len", lat, FRAME_SAT);
        @(negedge clk);
        check_eq("sat_rgb", rgbb, exp_rgb(GATE_SAT));
        check_eq("sat_busy_after", busyb, 0);

        // Reset in the middle of the green gate of a second frame
        per[0] = 5; per[3] = 10; per[1] = 20;
        run_frame(exp_rgb(GATE), e, 100000, 1'b1);
        repeat (170) @(negedge clk);
        check_eq("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        en = 1'b0;
        #1;
        check_eq("mid_rst_rgb", rgb, 24'h0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_dv", dv, 0);
        check_eq("mid_rst_flt", {s2, s3}, 2'b00);
        @(negedge clk);
        per[0] = 8;
        rst_n = 1'b1;
        e = exp_rgb(GATE);
        run_frame(e, 24'h0, 1, 1'b0);

        // Enable dropped during blue settle: frame still completes once
        per[0] = 20; per[3] = 4; per[1] = 10;
        run_frame(exp_rgb(GATE), e, 230, 1'b0);
        dv_base = dv_cnt;
        repeat (2000) @(negedge clk);
        check_eq("no_extra_dv", dv_cnt - dv_base, 0);
        check_eq("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
